// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with in-order response routing

module mem_arbiter_id_fifo #(
    parameter int DepthLog2 = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic full,
    output logic empty
);
    localparam int Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0] FullCount = {1'b1, {DepthLog2{1'b0}}};

    logic [Depth-1:0]     ids;
    logic [DepthLog2-1:0] wr_ptr;
    logic [DepthLog2-1:0] rd_ptr;
    logic [DepthLog2:0]   count;

    assign head_id = ids[rd_ptr];
    assign full    = (count == FullCount);
    assign empty   = (count == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + DepthLog2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DepthLog2'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (DepthLog2 + 1)'(1);
                2'b01:   count <= count - (DepthLog2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_arbiter #(
    parameter int DepthLog2 = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_valid_i,
    output logic        p0_ready_o,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic [3:0]  p0_wmask_i,
    output logic [31:0] p0_rdata_o,
    output logic        p0_rvalid_o,
    input  logic        p1_valid_i,
    output logic        p1_ready_o,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    input  logic [3:0]  p1_wmask_i,
    output logic [31:0] p1_rdata_o,
    output logic        p1_rvalid_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    output logic        err_o
);
    typedef enum logic {
        OPEN,
        LOCKED
    } state_t;

    state_t state;
    state_t state_next;
    logic   lock_grant;
    logic   lock_grant_next;
    logic   last_grant;
    logic   grant;
    logic   granted_valid;
    logic   accept;
    logic   lock_drop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   head_id;
    logic   pop;

    // last_grant resets to 1 so that port 0 wins the first tie.
    assign grant = (state == LOCKED)         ? lock_grant :
                   (p0_valid_i && p1_valid_i) ? ~last_grant : p1_valid_i;

    assign granted_valid = grant ? p1_valid_i : p0_valid_i;
    assign mem_valid_o   = granted_valid & ~fifo_full;
    assign mem_addr_o    = grant ? p1_addr_i  : p0_addr_i;
    assign mem_wdata_o   = grant ? p1_wdata_i : p0_wdata_i;
    assign mem_wmask_o   = grant ? p1_wmask_i : p0_wmask_i;
    assign p0_ready_o    = ~grant & mem_ready_i & ~fifo_full;
    assign p1_ready_o    =  grant & mem_ready_i & ~fifo_full;
    assign accept        = mem_valid_o & mem_ready_i;

    // Responses with nothing outstanding are dropped and flagged.
    assign pop         = mem_rvalid_i & ~fifo_empty;
    assign p0_rvalid_o = pop & ~head_id;
    assign p1_rvalid_o = pop &  head_id;
    assign p0_rdata_o  = mem_rdata_i;
    assign p1_rdata_o  = mem_rdata_i;

    mem_arbiter_id_fifo #(
        .DepthLog2(DepthLog2)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (accept),
        .push_id(grant),
        .pop    (pop),
        .head_id(head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_next      = state;
        lock_grant_next = lock_grant;
        lock_drop       = 1'b0;
        case (state)
            OPEN: begin
                if (mem_valid_o && !mem_ready_i) begin
                    state_next      = LOCKED;
                    lock_grant_next = grant;
                end
            end
            LOCKED: begin
                if (!granted_valid) begin
                    state_next = OPEN;
                    lock_drop  = 1'b1;
                end else if (accept) begin
                    state_next = OPEN;
                end
            end
            default: state_next = OPEN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= OPEN;
            lock_grant <= 1'b0;
            last_grant <= 1'b1;
            err_o      <= 1'b0;
        end else begin
            state      <= state_next;
            lock_grant <= lock_grant_next;
            if (accept) begin
                last_grant <= grant;
            end
            if (lock_drop || (mem_rvalid_i && fifo_empty)) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        p0_valid_i, p1_valid_i;
    logic        p0_ready_o, p1_ready_o;
    logic [31:0] p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i;
    logic [3:0]  p0_wmask_i, p1_wmask_i;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        p0_rvalid_o, p1_rvalid_o;
    logic        mem_valid_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wmask_o;
    logic        mem_rvalid_i;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.DepthLog2(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o), .p0_addr_i(p0_addr_i),
        .p0_wdata_i(p0_wdata_i), .p0_wmask_i(p0_wmask_i), .p0_rdata_o(p0_rdata_o),
        .p0_rvalid_o(p0_rvalid_o),
        .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_wmask_i(p1_wmask_i), .p1_rdata_o(p1_rdata_o),
        .p1_rvalid_o(p1_rvalid_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i), .err_o(err_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        p0_valid_i = 0; p1_valid_i = 0;
        p0_addr_i = 0; p1_addr_i = 0;
        p0_wdata_i = 32'h1111_0000; p1_wdata_i = 32'h2222_0000;
        p0_wmask_i = 4'h3; p1_wmask_i = 4'hC;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1;
        step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got %b expected 0", mem_valid_o); end
        checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got %b expected 00", {p1_rvalid_o, p0_rvalid_o}); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got %b expected 0", err_o); end
        checks++; if ({p1_ready_o, p0_ready_o} !== 2'b00) begin failures++; $display("FAIL reset_ready_nomem got %b expected 00", {p1_ready_o, p0_ready_o}); end
        mem_ready_i = 1;
        #1;
        checks++; if ({p1_ready_o, p0_ready_o} !== 2'b01) begin failures++; $display("FAIL reset_ready got %b expected 01", {p1_ready_o, p0_ready_o}); end
    endtask

    task automatic test_tie();
        logic exp_g;
        logic prev;
        do_reset();
        prev = 0;
        mem_ready_i = 1;
        p0_valid_i = 1; p1_valid_i = 1;
        p0_addr_i = 32'h1000; p1_addr_i = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2) == 1;
            mem_rvalid_i = (i > 0);
            mem_rdata_i = 32'h50 + i;
            #1;
            checks++; if (mem_addr_o !== (exp_g ? 32'h2000 : 32'h1000)) begin failures++; $display("FAIL tie_addr cycle %0d got %h expected %h", i, mem_addr_o, exp_g ? 32'h2000 : 32'h1000); end
            checks++; if ({p1_ready_o, p0_ready_o} !== (exp_g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_ready cycle %0d got %b expected %b", i, {p1_ready_o, p0_ready_o}, exp_g ? 2'b10 : 2'b01); end
            checks++; if (mem_wmask_o !== (exp_g ? 4'hC : 4'h3)) begin failures++; $display("FAIL tie_wmask cycle %0d got %h expected %h", i, mem_wmask_o, exp_g ? 4'hC : 4'h3); end
            if (i > 0) begin
                checks++; if ({p1_rvalid_o, p0_rvalid_o} !== (prev ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_rvalid cycle %0d got %b expected %b", i, {p1_rvalid_o, p0_rvalid_o}, prev ? 2'b10 : 2'b01); end
            end
            prev = exp_g;
            step();
        end
        p0_valid_i = 0; p1_valid_i = 0;
        mem_rvalid_i = 1;
        #1;
        checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b10) begin failures++; $display("FAIL tie_last_rvalid got %b expected 10", {p1_rvalid_o, p0_rvalid_o}); end
        step();
        mem_rvalid_i = 0;
    endtask

    task automatic test_lock();
        do_reset();
        mem_ready_i = 0;
        p1_valid_i = 1; p1_addr_i = 32'h100;
        p0_addr_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) p0_valid_i = 1;
            #1;
            checks++; if (mem_addr_o !== 32'h100) begin failures++; $display("FAIL lock_addr cycle %0d got %h expected 00000100", i, mem_addr_o); end
            checks++; if (p0_ready_o !== 1'b0) begin failures++; $display("FAIL lock_p0_ready cycle %0d got %b expected 0", i, p0_ready_o); end
            step();
        end
        mem_ready_i = 1;
        #1;
        checks++; if (mem_addr_o !== 32'h100 || p1_ready_o !== 1'b1) begin failures++; $display("FAIL lock_accept got addr %h ready %b expected 00000100 1", mem_addr_o, p1_ready_o); end
        step();
        #1;
        checks++; if (mem_addr_o !== 32'h200 || p0_ready_o !== 1'b1) begin failures++; $display("FAIL lock_next_grant got addr %h ready %b expected 00000200 1", mem_addr_o, p0_ready_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL lock_err got %b expected 0", err_o); end
        step();
    endtask

    task automatic test_lock_drop();
        do_reset();
        mem_ready_i = 0;
        p1_valid_i = 1;
        #1;
        step();
        p1_valid_i = 0; p0_valid_i = 1;
        #1;
        checks++; if (p0_ready_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL drop_during got ready %b err %b expected 0 0", p0_ready_o, err_o); end
        step();
        mem_ready_i = 1;
        #1;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL drop_err got %b expected 1", err_o); end
        checks++; if (p0_ready_o !== 1'b1) begin failures++; $display("FAIL drop_reopen got %b expected 1", p0_ready_o); end
        step();
    endtask

    task automatic test_full();
        do_reset();
        mem_ready_i = 1;
        p0_valid_i = 1; p0_addr_i = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (mem_valid_o !== (i < 4)) begin failures++; $display("FAIL full_fill cycle %0d got %b expected %b", i, mem_valid_o, i < 4); end
            step();
        end
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #1;
        checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'h77) begin failures++; $display("FAIL full_pop got rvalid %b data %h expected 1 00000077", p0_rvalid_o, p0_rdata_o); end
        checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL full_no_bypass got %b expected 0", mem_valid_o); end
        step();
        mem_rvalid_i = 0;
        #1;
        checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL full_reaccept got %b expected 1", mem_valid_o); end
        step();
        #1;
        checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL full_refull got %b expected 0", mem_valid_o); end
    endtask

    task automatic test_interleaved();
        logic [3:0] ord;
        logic [31:0] d;
        ord = 4'b0110;
        do_reset();
        mem_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            p0_valid_i = ~ord[i]; p1_valid_i = ord[i];
            #1;
            checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL inter_accept %0d got %b expected 1", i, mem_valid_o); end
            step();
        end
        p0_valid_i = 0; p1_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            d = 32'hA + i;
            mem_rvalid_i = 1; mem_rdata_i = d;
            #1;
            checks++; if ({p1_rvalid_o, p0_rvalid_o} !== (ord[i] ? 2'b10 : 2'b01)) begin failures++; $display("FAIL inter_route resp %h got %b expected %b", d, {p1_rvalid_o, p0_rvalid_o}, ord[i] ? 2'b10 : 2'b01); end
            checks++; if (p0_rdata_o !== d || p1_rdata_o !== d) begin failures++; $display("FAIL inter_rdata got %h/%h expected %h", p0_rdata_o, p1_rdata_o, d); end
            step();
        end
        mem_rvalid_i = 0;
        #1;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL inter_err got %b expected 0", err_o); end
    endtask

    task automatic test_spurious();
        do_reset();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD;
        #1;
        checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b00) begin failures++; $display("FAIL spur_rvalid got %b expected 00", {p1_rvalid_o, p0_rvalid_o}); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL spur_err_early got %b expected 0", err_o); end
        step();
        mem_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL spur_err_sticky cycle %0d got %b expected 1", i, err_o); end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem_rvalid_i = 1;
        step();
        mem_rvalid_i = 0;
        mem_ready_i = 1; p0_valid_i = 1;
        for (int i = 0; i < 3; i++) step();
        idle();
        rst_i = 1;
        step();
        rst_i = 0;
        mem_ready_i = 1;
        p0_valid_i = 1; p1_valid_i = 1;
        p0_addr_i = 32'h4000; p1_addr_i = 32'h5000;
        #1;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL mid_err got %b expected 0", err_o); end
        checks++; if (mem_addr_o !== 32'h4000 || p0_ready_o !== 1'b1) begin failures++; $display("FAIL mid_tie got addr %h ready %b expected 00004000 1", mem_addr_o, p0_ready_o); end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mem_valid_o !== (i < 4)) begin failures++; $display("FAIL mid_count cycle %0d got %b expected %b", i, mem_valid_o, i < 4); end
            step();
        end
    endtask

    initial begin
        idle();
        rst_i = 1;
        test_reset();
        test_tie();
        test_lock();
        test_lock_drop();
        test_full();
        test_interleaved();
        test_spurious();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have a parameter DepthLog2, default 2: log2 of the maximum number of outstanding (accepted, unanswered) requests, giving 4 by default.
REQ-002 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have the port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the requester ports p0_valid_i (in, 1), p0_ready_o (out, 1), p0_addr_i (in, 32), p0_wdata_i (in, 32), p0_wmask_i (in, 4), p0_rdata_o (out, 32) and p0_rvalid_o (out, 1); port 0 is the instruction side.
REQ-005 The block SHALL have the requester ports p1_valid_i, p1_ready_o, p1_addr_i, p1_wdata_i, p1_wmask_i, p1_rdata_o and p1_rvalid_o, with the same directions and widths as port 0; port 1 is the data side.
REQ-006 The block SHALL have the memory ports mem_valid_o (out, 1), mem_ready_i (in, 1), mem_addr_o (out, 32), mem_wdata_o (out, 32), mem_wmask_o (out, 4), mem_rdata_i (in, 32) and mem_rvalid_i (in, 1).
REQ-007 The block SHALL have the port err_o, output, 1 bit: a sticky flag for protocol violations.

Function
REQ-008 Handshake: a transfer SHALL occur when valid and ready are both high in the same cycle. The memory returns exactly one mem_rvalid_i pulse per accepted request, read or write, in acceptance order, no earlier than the cycle after acceptance.
REQ-009 Arbitration SHALL be combinational and zero-latency. The mux SHALL drive mem_valid_o, mem_addr_o, mem_wdata_o and mem_wmask_o from the granted port; mem_valid_o = granted valid AND NOT full.
REQ-010 The granted port SHALL see pN_ready_o = mem_ready_i AND NOT full. The non-granted port's ready SHALL be 0.
REQ-011 Round-robin: when only one port is valid, that port SHALL be granted. When both are valid, the port NOT granted at the last accepted transfer SHALL be granted.
REQ-012 FSM states SHALL be OPEN and LOCKED.
 - OPEN -> LOCKED when mem_valid_o=1 and mem_ready_i=0; the current grant is stored.
 - LOCKED holds the stored grant regardless of the other port; LOCKED -> OPEN on the accepting cycle (mem_valid_o and mem_ready_i).
 - If the locked port drops valid (a requester violation), err_o SHALL be set and the FSM SHALL return to OPEN.
REQ-013 Outstanding tracker: a FIFO of 2^DepthLog2 one-bit port IDs.
 - Push the granted ID on every accepted transfer.
 - Pop on mem_rvalid_i.
 - Occupancy count is DepthLog2+1 bits wide; pointers wrap modulo depth.
REQ-014 Full (count == depth) SHALL block grants even when a pop occurs in the same cycle (no pop-to-push bypass).
REQ-015 A simultaneous push and pop SHALL leave the count unchanged and keep both pointers correct.
REQ-016 Response routing: on mem_rvalid_i, pN_rvalid_o SHALL be asserted only for N = head ID, in the same cycle (combinational). Both p0_rdata_o and p1_rdata_o SHALL equal mem_rdata_i at all times.
REQ-017 mem_rvalid_i while the FIFO is empty SHALL be dropped: no rvalid to either port, err_o set, count stays 0.
REQ-018 A port may hold its request while its own earlier responses are pending. Ordering is guaranteed solely by the FIFO.

Reset
REQ-019 While rst_i is high at a clock edge, the block SHALL take the following values on the next cycle:
 - FSM = OPEN.
 - FIFO count and pointers = 0.
 - Round-robin state such that port 0 wins the first tie.
 - err_o = 0.
REQ-020 After reset, with all inputs low, the outputs SHALL be mem_valid_o=0, p0_rvalid_o=0 and p1_rvalid_o=0. Ready outputs follow REQ-010 combinationally.
REQ-021 Reset mid-operation SHALL discard all outstanding IDs. Responses arriving afterward fall under REQ-017; the bench resets the memory together with the arbiter.
REQ-022 err_o SHALL clear only on reset.

Verification
REQ-023 Tie, memory always ready, zero latency: p0 and p1 both valid for 4 cycles -> grants alternate 0,1,0,1; mem_addr_o tracks the granted port's address.
REQ-024 Lock: p1 valid (addr 0x100), mem_ready_i=0 for 3 cycles, p0 becomes valid in cycle 2 -> mem_addr_o stays 0x100 until acceptance; p0 is granted on the next cycle.
REQ-025 Full: mem_rvalid_i held 0, p0 continuously valid -> exactly 4 accepts, then mem_valid_o=0. A single rvalid pulse -> p0_rvalid_o=1 that cycle and one new accept the following cycle.
REQ-026 Interleaved: accept order p0,p1,p1,p0, responses 0xA,0xB,0xC,0xD -> p0_rvalid_o on responses 0xA and 0xD; p1_rvalid_o on 0xB and 0xC.
REQ-027 Spurious response: mem_rvalid_i=1 with the FIFO empty -> no port rvalid; err_o=1 from the next cycle until rst_i.
REQ-028 Reset mid-flight: 3 outstanding, then rst_i for 1 cycle -> count=0, err_o=0; the next tie is granted to p0.
